issue_scheduler: RTL

- Issue-stage controller between Decode and the functional units (ALU, SHIFT, MEM).
- Keeps a per-register scoreboard of in-flight writes and decides each cycle whether the instruction held in the Decode output registers can issue.
- Drives iss_stall back to Decode and a one-hot start to the selected unit.
- Arbitrates the single register-file write port among unit writeback requests using round-robin.

---
 rtl/issue_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 66 ++++++
 rtl/issue_scheduler.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/issue_pkg.sv
// Shared definitions for the issue stage: functional-unit indices, the
// register-file write-select encoding, and the register address width.
// No ports (package).
package issue_pkg;

  localparam int REG_AW   = 5;
  localparam int NUM_FU   = 3;
  localparam int FU_ALU   = 0;
  localparam int FU_SHIFT = 1;
  localparam int FU_MEM   = 2;

  // Result-mux select driven alongside the register-file write port.
  typedef enum logic [1:0] {
    WSEL_ALU   = 2'd0,
    WSEL_SHIFT = 2'd1,
    WSEL_MEM   = 2'd2
  } wsel_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for the single register-file write port.
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   req   [2:0]  : per-unit writeback requests {MEM,SHIFT,ALU}
//   grant [2:0]  : one-hot grant, forced to zero while reset is high
// The search starts at the pointer; after a grant the pointer moves to the
// index just past the winner (2 wraps to 0). With no request it holds.
module rr_arbiter
  import issue_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_FU-1:0] req,
  output logic [NUM_FU-1:0] grant
);

  logic [1:0] rr;
  logic [1:0] rr_next;

  // First requester at or after the pointer wins.
  always_comb begin
    grant = 3'b000;
    if (reset) begin
      grant = 3'b000;
    end else begin
      case (rr)
        2'd1: begin
          if (req[1])      grant = 3'b010;
          else if (req[2]) grant = 3'b100;
          else if (req[0]) grant = 3'b001;
          else             grant = 3'b000;
        end
        2'd2: begin
          if (req[2])      grant = 3'b100;
          else if (req[0]) grant = 3'b001;
          else if (req[1]) grant = 3'b010;
          else             grant = 3'b000;
        end
        default: begin
          if (req[0])      grant = 3'b001;
          else if (req[1]) grant = 3'b010;
          else if (req[2]) grant = 3'b100;
          else             grant = 3'b000;
        end
      endcase
    end
  end

  // Pointer advances past the winner; holds when nothing is granted.
  always_comb begin
    rr_next = rr;
    case (grant)
      3'b001:  rr_next = 2'd1;
      3'b010:  rr_next = 2'd2;
      3'b100:  rr_next = 2'd0;
      default: rr_next = rr;
    endcase
  end

  // Pointer register.
  always_ff @(posedge clock) begin
    if (reset) rr <= 2'd0;
    else       rr <= rr_next;
  end

endmodule

// File: rtl/issue_scheduler.sv
// Issue-stage controller between Decode and the ALU/SHIFT/MEM units.
// Tracks in-flight register writes in a scoreboard, stalls Decode on
// RAW/WAW/unit-busy hazards, issues with zero latency, and arbitrates the
// register-file write port round-robin among unit writebacks.
// Ports:
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   id_iss_*              : instruction held in the Decode output registers
//   fu_busy [2:0]         : per unit {MEM,SHIFT,ALU} cannot accept an op
//   fu_wb_req [2:0]       : per unit writeback request, held until granted
//   fu_wb_addr [14:0]     : per unit destination {MEM,SHIFT,ALU} x 5 bits
//   iss_stall             : hold Decode registers
//   iss_fu_start [2:0]    : one-hot issue strobe
//   wb_grant [2:0]        : one-hot writeback grant
//   iss_reg_we/waddr/wsel : register-file write port and result-mux select
//   iss_wb_err            : sticky, writeback to a register not pending
//   iss_stall_cnt         : saturating count of stalled cycles
// Build option: define ISS_WB_BYPASS_EN to let a register being written back
// this cycle satisfy the source-operand check (write-first register file).
module issue_scheduler
  import issue_pkg::*;
#(
  parameter int NREG  = 32,
  parameter int CNT_W = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     id_iss_valid,
  input  logic [REG_AW-1:0]        id_iss_addra,
  input  logic [REG_AW-1:0]        id_iss_addrb,
  input  logic [REG_AW-1:0]        id_iss_regdest,
  input  logic                     id_iss_writereg,
  input  logic                     id_iss_selimregb,
  input  logic                     id_iss_selalushift,
  input  logic                     id_iss_readmem,
  input  logic                     id_iss_writemem,
  input  logic [NUM_FU-1:0]        fu_busy,
  input  logic [NUM_FU-1:0]        fu_wb_req,
  input  logic [NUM_FU*REG_AW-1:0] fu_wb_addr,
  output logic                     iss_stall,
  output logic [NUM_FU-1:0]        iss_fu_start,
  output logic [NUM_FU-1:0]        wb_grant,
  output logic                     iss_reg_we,
  output logic [REG_AW-1:0]        iss_reg_waddr,
  output logic [1:0]               iss_reg_wsel,
  output logic                     iss_wb_err,
  output logic [CNT_W-1:0]         iss_stall_cnt
);

  logic [NREG-1:0]   pending;
  logic [NREG-1:0]   pending_next;
  logic [NREG-1:0]   src_pending;
  logic [NREG-1:0]   grant_dec;
  logic [NREG-1:0]   set_dec;
  logic [NUM_FU-1:0] unit_oh;
  logic [NUM_FU-1:0] grant;
  logic [REG_AW-1:0] g_addr;
  wsel_e             g_wsel;
  logic              g_any;
  logic              use_rt;
  logic              hazard;
  logic              issue;

  rr_arbiter u_arb (
    .clock (clock),
    .reset (reset),
    .req   (fu_wb_req),
    .grant (grant)
  );

  // Unit select: memory ops first, then shifts, everything else to the ALU.
  always_comb begin
    unit_oh = 3'b001;
    if (id_iss_readmem || id_iss_writemem) unit_oh = 3'b100;
    else if (id_iss_selalushift)           unit_oh = 3'b010;
    else                                   unit_oh = 3'b001;
  end

  // Writeback address and result-mux select follow the granted unit.
  always_comb begin
    g_addr = 5'd0;
    g_wsel = WSEL_ALU;
    case (grant)
      3'b001: begin g_addr = fu_wb_addr[4:0];   g_wsel = WSEL_ALU;   end
      3'b010: begin g_addr = fu_wb_addr[9:5];   g_wsel = WSEL_SHIFT; end
      3'b100: begin g_addr = fu_wb_addr[14:10]; g_wsel = WSEL_MEM;   end
      default: begin g_addr = 5'd0;             g_wsel = WSEL_ALU;   end
    endcase
  end

  assign g_any = |grant;

  // Decoded clear (grant) and set (issue) masks for the scoreboard.
  always_comb begin
    grant_dec = '0;
    set_dec   = '0;
    if (g_any) grant_dec[g_addr] = 1'b1;
    else       grant_dec = '0;
    if (issue && id_iss_writereg && (id_iss_regdest != 5'd0)) set_dec[id_iss_regdest] = 1'b1;
    else                                                     set_dec = '0;
  end

`ifdef ISS_WB_BYPASS_EN
  // A register written this cycle is already visible to readers.
  assign src_pending = pending & ~grant_dec;
`else
  assign src_pending = pending;
`endif

  // Stores read rt even when operand B is the immediate.
  assign use_rt = ~id_iss_selimregb | id_iss_writemem;

  // WAW uses the raw scoreboard so bypass never hides an older write.
  assign hazard = ((id_iss_addra != 5'd0) & src_pending[id_iss_addra])
                | (use_rt & (id_iss_addrb != 5'd0) & src_pending[id_iss_addrb])
                | (id_iss_writereg & (id_iss_regdest != 5'd0) & pending[id_iss_regdest])
                | (|(fu_busy & unit_oh));

  assign issue         = ~reset & id_iss_valid & ~hazard;
  assign iss_stall     = ~reset & id_iss_valid & hazard;
  assign iss_fu_start  = issue ? unit_oh : 3'b000;
  assign wb_grant      = grant;
  assign iss_reg_we    = g_any;
  assign iss_reg_waddr = g_addr;
  assign iss_reg_wsel  = g_wsel;

  // Set beats clear on the same register; register 0 is never pending.
  always_comb begin
    pending_next    = (pending & ~grant_dec) | set_dec;
    pending_next[0] = 1'b0;
  end

  // Scoreboard, sticky error flag and saturating stall counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      pending       <= '0;
      iss_wb_err    <= 1'b0;
      iss_stall_cnt <= '0;
    end else begin
      pending <= pending_next;
      if (g_any && (g_addr != 5'd0) && !pending[g_addr]) iss_wb_err <= 1'b1;
      if (iss_stall && (iss_stall_cnt != {CNT_W{1'b1}}))  iss_stall_cnt <= iss_stall_cnt + CNT_W'(1);
    end
  end

endmodule
